// File: rtl/sp_pkg.sv
// Shared definitions for the serial link (transmitter and receiver sides).
package sp_pkg;

  // Alignment / idle character recognised by the receiver.
  localparam logic [7:0] COMMA_BC = 8'hBC;

  // Bits per character on the serial line.
  localparam int BITS_PER_CHAR = 8;

  // Link state: sending the opening comma run, or carrying user data.
  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } tx_state_e;

  // Character for a slot: the held byte once the link runs and one is waiting, else the comma.
  function automatic logic [7:0] select_char(input logic       in_run,
                                             input logic       full,
                                             input logic [7:0] hold,
                                             input logic [7:0] comma);
    select_char = (in_run && full) ? hold : comma;
  endfunction

endpackage

// File: rtl/paralelo_serial_tx_if.sv
// Byte handshake in, serial line and status out, for the parallel-to-serial transmitter.
interface paralelo_serial_tx_if;
  import sp_pkg::*;

  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       active_out;
  logic       char_start;

  // Byte producer side (drives bytes, observes the line).
  modport master (
    output data_in, valid_in,
    input  ready_out, data_out, active_out, char_start
  );

  // Transmitter side.
  modport slave (
    input  data_in, valid_in,
    output ready_out, data_out, active_out, char_start
  );

endinterface

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: opens with a comma run, then shifts bytes out MSB-first,
// one bit per clock, filling empty slots with the comma character.
module paralelo_serial_tx
  import sp_pkg::*;
#(
  parameter logic [7:0] COMMA       = COMMA_BC,
  parameter int         SYNC_COMMAS = 4
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  paralelo_serial_tx_if.slave  bus
);

  localparam int            CNT_W     = $clog2(BITS_PER_CHAR);
  localparam logic [0:0]    ST_SYNC   = 1'(SYNC);
  localparam logic [0:0]    ST_RUN    = 1'(RUN);
  // Comma count value seen at the slot start that loads the last sync comma.
  localparam logic [2:0]    LAST_SYNC = 3'(SYNC_COMMAS - 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_comma_cnt;
  logic             r_full;
  logic [7:0]       r_hold;
  logic [6:0]       r_shift;      // bits still to send after the MSB already on the line
  logic             r_data_out;
  logic             r_char_start;

  logic             w_slot_start;
  logic             w_run;
  logic             w_ready;
  logic             w_accept;
  logic             w_take_hold;
  logic [7:0]       w_char;

  assign w_slot_start = (r_bit_cnt == '0);
  assign w_run        = (r_state == ST_RUN);
  assign w_ready      = w_run && !r_full;
  assign w_accept     = bus.valid_in && w_ready;
  assign w_take_hold  = w_slot_start && w_run && r_full;
  assign w_char       = select_char(w_run, r_full, r_hold, COMMA);

  assign bus.ready_out  = w_ready;
  assign bus.data_out   = r_data_out;
  assign bus.active_out = w_run;
  assign bus.char_start = r_char_start;

  // Free-running bit position within the current byte slot.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // Sync comma run: count commas started, enter RUN after the slot that loads the last one.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SYNC;
      r_comma_cnt <= '0;
    end else if (!w_run && w_slot_start) begin
      r_comma_cnt <= r_comma_cnt + 3'd1;
      if (r_comma_cnt == LAST_SYNC) begin
        r_state <= ST_RUN;
      end
    end
  end

  // One-byte holding register; ready is low while full, so accept and consume never coincide.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_hold <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_hold <= bus.data_in;
    end else if (w_take_hold) begin
      r_full <= 1'b0;
    end
  end

  // Shift register and registered line outputs: load at slot start, shift on the other edges.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_shift      <= '0;
      r_data_out   <= 1'b0;
      r_char_start <= 1'b0;
    end else begin
      r_char_start <= w_slot_start;
      if (w_slot_start) begin
        r_shift    <= w_char[6:0];
        r_data_out <= w_char[7];
      end else begin
        r_shift    <= {r_shift[5:0], 1'b0};
        r_data_out <= r_shift[6];
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Bench for paralelo_serial_tx: slot-level reference model of the line plus a receiver
// that reassembles characters from the line and matches them against accepted bytes.
module tb_paralelo_serial_tx;
  import sp_pkg::*;

  localparam int SYNC_N = 4;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_32f = ~clk_32f;

  paralelo_serial_tx_if bus ();

  paralelo_serial_tx #(.COMMA(COMMA_BC), .SYNC_COMMAS(SYNC_N)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset release, pending byte, link state, current character.
  int         n;
  bit         m_full;
  bit         m_run;
  logic [7:0] m_byte;
  logic [7:0] m_cur;
  bit         m_acc;
  logic [7:0] acc_q[$];   // accepted bytes not yet seen on the line

  // Receiver reassembling characters from the DUT line.
  int         rx_cnt;
  logic [7:0] rx_sh;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    m_full = 0;
    m_run  = 0;
    m_byte = 8'h00;
    m_cur  = 8'h00;
    m_acc  = 0;
    acc_q.delete();
    rx_cnt = -1;
    rx_sh  = 8'h00;
  endtask

  // One clock: predict from slot arithmetic, then compare every output.
  task automatic step();
    logic [7:0] din;
    int         ph;
    int         k;
    logic [7:0] exp_rx;
    din   = bus.data_in;
    m_acc = bus.valid_in && m_run && !m_full;
    @(posedge clk_32f);
    n++;
    ph = (n - 1) % BITS_PER_CHAR;
    if (ph == 0) begin
      k = (n - 1) / BITS_PER_CHAR;
      if (k < SYNC_N) begin
        m_cur = COMMA_BC;
      end else if (m_full) begin
        m_cur  = m_byte;
        m_full = 0;
      end else begin
        m_cur = COMMA_BC;
      end
      if (k == SYNC_N - 1) m_run = 1;
    end
    if (m_acc) begin
      m_full = 1;
      m_byte = din;
      acc_q.push_back(din);
      $display("cycle %0d: byte %02h accepted", n, din);
    end
    #1;
    check("data_out",   {7'd0, bus.data_out},   {7'd0, m_cur[7-ph]});
    check("char_start", {7'd0, bus.char_start}, (ph == 0) ? 8'd1 : 8'd0);
    check("active_out", {7'd0, bus.active_out}, {7'd0, m_run});
    check("ready_out",  {7'd0, bus.ready_out},  {7'd0, (m_run && !m_full)});
    if (bus.char_start) rx_cnt = 0;
    if (rx_cnt >= 0) begin
      rx_sh = {rx_sh[6:0], bus.data_out};
      rx_cnt++;
      if (rx_cnt == BITS_PER_CHAR) begin
        rx_cnt = -1;
        if (rx_sh != COMMA_BC) begin
          exp_rx = (acc_q.size() > 0) ? acc_q.pop_front() : COMMA_BC;
          $display("cycle %0d: line byte %02h received", n, rx_sh);
          check("loopback_byte", rx_sh, exp_rx);
        end
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Present one byte and hold valid until the model sees it accepted (bounded).
  task automatic send(input logic [7:0] b);
    int waited;
    bus.data_in  = b;
    bus.valid_in = 1'b1;
    waited = 0;
    m_acc  = 0;
    while (!m_acc && waited < 40) begin
      step();
      waited++;
    end
    bus.valid_in = 1'b0;
    check("send_timeout", {7'd0, m_acc}, 8'd1);
  endtask

  task automatic reset_cycle();
    @(posedge clk_32f);
    #1;
    check("rst_data_out",   {7'd0, bus.data_out},   8'd0);
    check("rst_ready_out",  {7'd0, bus.ready_out},  8'd0);
    check("rst_active_out", {7'd0, bus.active_out}, 8'd0);
    check("rst_char_start", {7'd0, bus.char_start}, 8'd0);
  endtask

  initial begin
    logic [7:0] rb;
    bus.data_in  = 8'h00;
    bus.valid_in = 1'b0;
    model_reset();

    // Reset held 4 cycles, then 64 idle cycles of sync and idle commas.
    for (int i = 0; i < 4; i++) reset_cycle();
    reset = 1'b0;
    idle(64);

    // Single byte with idle commas after it.
    send(8'hA5);
    idle(24);

    // Back-to-back stream 0x01..0x10.
    for (int v = 1; v <= 16; v++) send(8'(v));
    idle(24);

    // Accept exactly on a slot-start edge: that slot still carries the comma.
    while ((n % BITS_PER_CHAR) != 0) step();
    bus.data_in  = 8'h3C;
    bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    check("slot_edge_accept", {7'd0, m_acc}, 8'd1);
    idle(24);

    // Reset during bit 3 of 0x77 with another byte pending.
    send(8'h77);
    while (!(m_cur == 8'h77 && ((n - 1) % BITS_PER_CHAR) == 0)) step();
    send(8'h5A);
    while (((n - 1) % BITS_PER_CHAR) != 4) step();
    #3;
    reset = 1'b1;
    #1;
    check("midchar_data_out",  {7'd0, bus.data_out},   8'd0);
    check("midchar_ready_out", {7'd0, bus.ready_out},  8'd0);
    check("midchar_active",    {7'd0, bus.active_out}, 8'd0);
    $display("reset asserted mid-character, pending byte discarded");
    model_reset();
    reset_cycle();
    reset_cycle();
    reset = 1'b0;
    idle(48);

    // Random non-comma bytes with random gaps, checked through the receiver.
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom_range(0, 255));
      if (rb == COMMA_BC) rb = 8'h3D;
      idle($urandom_range(0, 3));
      send(rb);
    end
    idle(24);
    check("loopback_drained", 8'(acc_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
